// File: rtl/game_flow_controller_pkg.sv
// Shared definitions for the game flow controller: state encodings,
// dragon length commands and frame-count constants.
package game_flow_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_PLAY     = 2'b01,
        ST_HIT      = 2'b10,
        ST_GAMEOVER = 2'b11
    } state_e;

    localparam logic [1:0] LEN_HOLD   = 2'b00;
    localparam logic [1:0] LEN_GROW   = 2'b01;
    localparam logic [1:0] LEN_SHRINK = 2'b10;

    localparam logic [1:0] LIVES_INIT      = 2'd3;
    localparam int         INVULN_FRAMES   = 64;
    localparam int         GAMEOVER_FRAMES = 128;

    // Timer is loaded with N-1 so that the zero-check frame is the Nth one.
    localparam logic [6:0] HIT_LOAD      = 7'(INVULN_FRAMES - 1);
    localparam logic [6:0] GAMEOVER_LOAD = 7'(GAMEOVER_FRAMES - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        if (val == 8'd255) begin
            sat_inc8 = 8'd255;
        end else begin
            sat_inc8 = val + 8'd1;
        end
    endfunction

endpackage

// File: rtl/game_flow_controller_frame_timer.sv
// 7-bit frame down counter: load has priority, decrements on request,
// holds at zero.
module frame_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [6:0] load_val_i,
    input  logic       dec_i,
    output logic [6:0] count_o,
    output logic       zero_o
);

    logic [6:0] count_q;

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 7'd0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != 7'd0)) begin
            count_q <= count_q - 7'd1;
        end else begin
            count_q <= count_q;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == 7'd0);

endmodule

// File: rtl/game_flow_controller.sv
// Game flow FSM: lives, score, invulnerability and game-over timing, and
// dragon length commands, all advanced only on frame_end.
module game_flow_controller
    import game_flow_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_end,
    input  logic       start,
    input  logic       player_dragon_collision,
    input  logic       sword_dragon_collision,
    input  logic       sheep_dragon_collision,
    output logic [1:0] player_lives,
    output logic [1:0] length_update,
    output logic       entity_reset,
    output logic [1:0] game_state,
    output logic       hit_flash,
    output logic [7:0] score
);

    state_e     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [7:0] score_q, score_d;
    logic [1:0] len_q, len_d;
    logic       ent_rst_q, ent_rst_d;
    logic       flash_q, flash_d;

    logic       tmr_load_s;
    logic [6:0] tmr_val_s;
    logic       tmr_dec_s;
    logic [6:0] tmr_count_s;
    logic       tmr_zero_s;
    logic       items_en_s;
    logic       ends_game_s;

    frame_timer u_frame_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .dec_i      (tmr_dec_s),
        .count_o    (tmr_count_s),
        .zero_o     (tmr_zero_s)
    );

    // A player hit on the last life preempts any sword/sheep event that frame.
    assign ends_game_s = player_dragon_collision && (lives_q <= 2'd1);

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        score_d    = score_q;
        len_d      = LEN_HOLD;
        ent_rst_d  = 1'b0;
        tmr_load_s = 1'b0;
        tmr_val_s  = 7'd0;
        tmr_dec_s  = 1'b0;
        items_en_s = 1'b0;
        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    lives_d = LIVES_INIT;
                    if (start) begin
                        state_d   = ST_PLAY;
                        score_d   = 8'd0;
                        ent_rst_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (ends_game_s) begin
                        lives_d    = 2'd0;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = GAMEOVER_LOAD;
                        state_d    = ST_GAMEOVER;
                    end else if (player_dragon_collision) begin
                        lives_d    = lives_q - 2'd1;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = HIT_LOAD;
                        state_d    = ST_HIT;
                        items_en_s = 1'b1;
                    end else begin
                        items_en_s = 1'b1;
                    end
                end
                ST_HIT: begin
                    items_en_s = 1'b1;
                    if (tmr_zero_s) begin
                        state_d = ST_PLAY;
                    end else begin
                        tmr_dec_s = 1'b1;
                    end
                end
                ST_GAMEOVER: begin
                    if (tmr_zero_s) begin
                        state_d = ST_IDLE;
                        lives_d = LIVES_INIT;
                    end else begin
                        tmr_dec_s = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (items_en_s && sword_dragon_collision) begin
            len_d   = LEN_SHRINK;
            score_d = sat_inc8(score_q);
        end else if (items_en_s && sheep_dragon_collision) begin
            len_d = LEN_GROW;
        end else begin
            len_d = LEN_HOLD;
        end

        flash_d = (state_d == ST_HIT);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lives_q   <= LIVES_INIT;
            score_q   <= 8'd0;
            len_q     <= LEN_HOLD;
            ent_rst_q <= 1'b0;
            flash_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            score_q   <= score_d;
            len_q     <= len_d;
            ent_rst_q <= ent_rst_d;
            flash_q   <= flash_d;
        end
    end

    assign player_lives  = lives_q;
    assign length_update = len_q;
    assign entity_reset  = ent_rst_q;
    assign game_state    = state_q;
    assign hit_flash     = flash_q;
    assign score         = score_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed self-checking bench for game_flow_controller.
module tb_game_flow_controller;

    logic       clk;
    logic       reset;
    logic       frame_end;
    logic       start;
    logic       pd_col;
    logic       sw_col;
    logic       sh_col;
    logic [1:0] player_lives;
    logic [1:0] length_update;
    logic       entity_reset;
    logic [1:0] game_state;
    logic       hit_flash;
    logic [7:0] score;

    int checks;
    int errors;

    game_flow_controller dut (
        .clk                     (clk),
        .reset                   (reset),
        .frame_end               (frame_end),
        .start                   (start),
        .player_dragon_collision (pd_col),
        .sword_dragon_collision  (sw_col),
        .sheep_dragon_collision  (sh_col),
        .player_lives            (player_lives),
        .length_update           (length_update),
        .entity_reset            (entity_reset),
        .game_state              (game_state),
        .hit_flash               (hit_flash),
        .score                   (score)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame_end cycle with the given inputs; returns at the following
    // negedge, where the registered results are visible.
    task automatic do_frame(input logic s, input logic pd, input logic sw, input logic sh);
        @(negedge clk);
        frame_end = 1'b1;
        start     = s;
        pd_col    = pd;
        sw_col    = sw;
        sh_col    = sh;
        @(negedge clk);
        frame_end = 1'b0;
        start     = 1'b0;
        pd_col    = 1'b0;
        sw_col    = 1'b0;
        sh_col    = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] st, input logic [1:0] lv,
                              input logic [7:0] sc, input logic [1:0] lu, input logic er,
                              input logic hf);
        check_eq({tag, ".state"}, 32'(game_state), 32'(st));
        check_eq({tag, ".lives"}, 32'(player_lives), 32'(lv));
        check_eq({tag, ".score"}, 32'(score), 32'(sc));
        check_eq({tag, ".len"}, 32'(length_update), 32'(lu));
        check_eq({tag, ".erst"}, 32'(entity_reset), 32'(er));
        check_eq({tag, ".flash"}, 32'(hit_flash), 32'(hf));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        frame_end = 1'b0;
        start     = 1'b0;
        pd_col    = 1'b0;
        sw_col    = 1'b0;
        sh_col    = 1'b0;
        repeat (3) @(negedge clk);
        check_outs("reset", 2'd0, 2'd3, 8'd0, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;

        // Frame without start stays idle; start enters PLAY with one-cycle entity reset.
        do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("idle_hold", 32'(game_state), 32'd0);
        do_frame(1'b1, 1'b0, 1'b0, 1'b0);
        check_outs("start", 2'd1, 2'd3, 8'd0, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("erst_one_cycle", 32'(entity_reset), 32'd0);

        // Collisions between frame_end pulses do nothing.
        pd_col = 1'b1; sw_col = 1'b1; sh_col = 1'b1; start = 1'b1;
        repeat (4) @(negedge clk);
        pd_col = 1'b0; sw_col = 1'b0; sh_col = 1'b0; start = 1'b0;
        check_outs("no_frame", 2'd1, 2'd3, 8'd0, 2'd0, 1'b0, 1'b0);

        // First hit, then collision held through invulnerability.
        do_frame(1'b0, 1'b1, 1'b0, 1'b0);
        check_outs("hit1", 2'd2, 2'd2, 8'd0, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 63; i++) do_frame(1'b0, 1'b1, 1'b0, 1'b0);
        check_outs("hit1_held63", 2'd2, 2'd2, 8'd0, 2'd0, 1'b0, 1'b1);
        do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check_outs("hit1_end", 2'd1, 2'd2, 8'd0, 2'd0, 1'b0, 1'b0);

        // Sword + sheep together shrinks and scores; sheep alone grows.
        do_frame(1'b0, 1'b0, 1'b1, 1'b1);
        check_outs("sword_sheep", 2'd1, 2'd2, 8'd1, 2'd2, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("len_pulse", 32'(length_update), 32'd0);
        do_frame(1'b0, 1'b0, 1'b0, 1'b1);
        check_outs("sheep", 2'd1, 2'd2, 8'd1, 2'd1, 1'b0, 1'b0);

        // Second hit with a sword strike in the same frame, then a HIT-state grow.
        do_frame(1'b0, 1'b1, 1'b1, 1'b0);
        check_outs("hit2", 2'd2, 2'd1, 8'd2, 2'd2, 1'b0, 1'b1);
        do_frame(1'b0, 1'b1, 1'b0, 1'b1);
        check_outs("hit2_sheep", 2'd2, 2'd1, 8'd2, 2'd1, 1'b0, 1'b1);
        for (int i = 0; i < 63; i++) do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("hit2_end", 32'(game_state), 32'd1);

        // Final hit ends the game; the simultaneous sword strike is dropped.
        do_frame(1'b0, 1'b1, 1'b1, 1'b0);
        check_outs("gameover", 2'd3, 2'd0, 8'd2, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 127; i++) do_frame(1'b1, 1'b0, 1'b0, 1'b0);
        check_outs("go_held127", 2'd3, 2'd0, 8'd2, 2'd0, 1'b0, 1'b0);
        do_frame(1'b1, 1'b0, 1'b0, 1'b0);
        check_outs("go_end", 2'd0, 2'd3, 8'd2, 2'd0, 1'b0, 1'b0);

        // New game clears score; 256 sword hits saturate at 255.
        do_frame(1'b1, 1'b0, 1'b0, 1'b0);
        check_outs("start2", 2'd1, 2'd3, 8'd0, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 255; i++) do_frame(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("score255", 32'(score), 32'd255);
        do_frame(1'b0, 1'b0, 1'b1, 1'b0);
        check_outs("score_sat", 2'd1, 2'd3, 8'd255, 2'd2, 1'b0, 1'b0);

        // Reset in the middle of HIT.
        do_frame(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("hit3_state", 32'(game_state), 32'd2);
        for (int i = 0; i < 5; i++) do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1 check_outs("mid_hit_reset", 2'd0, 2'd3, 8'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        do_frame(1'b0, 1'b1, 1'b1, 1'b0);
        check_outs("post_reset", 2'd0, 2'd3, 8'd0, 2'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
